ex_stage: RTL

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and resolves operand forwarding from the EX/MEM and MEM/WB stages. It evaluates the ALU and captures the results, together with the surviving control bits, in its own EX/MEM pipeline register, which feeds the MEM stage. The registered outputs also act as the EX/MEM forwarding source for the next instruction.

---
 rtl/ex_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU and EX/MEM register; 1-cycle latency.
// stall freezes the EX/MEM register (forwarding source stays valid), flush loads a bubble.
module ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        PCWre,
    input  logic        if_wr_reg,
    input  logic        isLW,
    input  logic        ALUSrcB,
    input  logic        ALUM2Reg,
    input  logic        DataMemRW,
    input  logic [2:0]  ALUOp,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] targPcOut_ID,
    input  logic [31:0] immediate_32,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        rs_src,
    input  logic        rt_src,
    input  logic [4:0]  targReg,
    input  logic        wb_wr_reg,
    input  logic [4:0]  wb_targReg,
    input  logic [31:0] wb_data,
    output logic        PCWre_EX_MEM_out,
    output logic        if_wr_reg_EX_MEM_out,
    output logic        isLW_EX_MEM_out,
    output logic        ALUM2Reg_EX_MEM_out,
    output logic        DataMemRW_EX_MEM_out,
    output logic [31:0] aluResult_EX_MEM_out,
    output logic [31:0] storeData_EX_MEM_out,
    output logic [31:0] targPc_EX_MEM_out,
    output logic [4:0]  targReg_EX_MEM_out,
    output logic        zero_EX_MEM_out
);

    typedef struct packed {
        logic        pc_wre;
        logic        wr_reg;
        logic        is_lw;
        logic        alu_m2reg;
        logic        mem_rw;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] targ_pc;
        logic [4:0]  targ_reg;
        logic        zero;
    } ex_mem_t;

    ex_mem_t     ex_mem_q, ex_mem_d;
    logic [31:0] a_fwd, b_fwd, alu_b, alu_res;
    logic        exm_fwd_ok;

    // A load's EX/MEM result is an address, not data: loaded values arrive via MEM/WB only.
    assign exm_fwd_ok = ex_mem_q.wr_reg && !ex_mem_q.is_lw;

    always_comb begin
        a_fwd = readData1;
        if (rs_src && rs != 5'd0 && exm_fwd_ok && ex_mem_q.targ_reg == rs)
            a_fwd = ex_mem_q.alu_result;
        else if (rs_src && rs != 5'd0 && wb_wr_reg && wb_targReg == rs)
            a_fwd = wb_data;

        b_fwd = readData2;
        if (rt_src && rt != 5'd0 && exm_fwd_ok && ex_mem_q.targ_reg == rt)
            b_fwd = ex_mem_q.alu_result;
        else if (rt_src && rt != 5'd0 && wb_wr_reg && wb_targReg == rt)
            b_fwd = wb_data;

        alu_b = ALUSrcB ? immediate_32 : b_fwd;
    end

    always_comb begin
        alu_res = 32'h0;
        case (ALUOp)
            3'b000:  alu_res = a_fwd + alu_b;
            3'b001:  alu_res = a_fwd - alu_b;
            3'b010:  alu_res = a_fwd & alu_b;
            3'b011:  alu_res = a_fwd | alu_b;
            3'b100:  alu_res = a_fwd ^ alu_b;
            3'b101:  alu_res = {31'h0, $signed(a_fwd) < $signed(alu_b)};
            3'b110:  alu_res = {31'h0, a_fwd < alu_b};
            3'b111:  alu_res = alu_b << a_fwd[4:0];
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush) begin
            ex_mem_d = '0;
        end else if (!stall) begin
            ex_mem_d.pc_wre     = PCWre;
            ex_mem_d.wr_reg     = if_wr_reg;
            ex_mem_d.is_lw      = isLW;
            ex_mem_d.alu_m2reg  = ALUM2Reg;
            ex_mem_d.mem_rw     = DataMemRW;
            ex_mem_d.alu_result = alu_res;
            ex_mem_d.store_data = b_fwd;
            ex_mem_d.targ_pc    = targPcOut_ID;
            ex_mem_d.targ_reg   = targReg;
            ex_mem_d.zero       = (alu_res == 32'h0);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) ex_mem_q <= '0;
        else        ex_mem_q <= ex_mem_d;
    end

    assign PCWre_EX_MEM_out     = ex_mem_q.pc_wre;
    assign if_wr_reg_EX_MEM_out = ex_mem_q.wr_reg;
    assign isLW_EX_MEM_out      = ex_mem_q.is_lw;
    assign ALUM2Reg_EX_MEM_out  = ex_mem_q.alu_m2reg;
    assign DataMemRW_EX_MEM_out = ex_mem_q.mem_rw;
    assign aluResult_EX_MEM_out = ex_mem_q.alu_result;
    assign storeData_EX_MEM_out = ex_mem_q.store_data;
    assign targPc_EX_MEM_out    = ex_mem_q.targ_pc;
    assign targReg_EX_MEM_out   = ex_mem_q.targ_reg;
    assign zero_EX_MEM_out      = ex_mem_q.zero;

endmodule
